// File: rtl/stall_collapse_pipe_if.sv
// Handshake and segmented datapath bundle for stall_collapse_pipe.
// Signal suffixes are named from the pipeline's point of view (slave side).
interface stall_collapse_pipe_if #(
    parameter int stages_p    = 3,
    parameter int width_sum_p = 112
);
    logic                   valid_i;
    logic                   ready_and_o;
    logic                   valid_o;
    logic                   ready_and_i;
    logic [width_sum_p-1:0] data_i;
    logic [width_sum_p-1:0] data_o;
    logic [stages_p-1:0]    en_o;

    modport slave (
        input  valid_i, ready_and_i, data_i,
        output ready_and_o, valid_o, data_o, en_o
    );

    modport master (
        output valid_i, ready_and_i, data_i,
        input  ready_and_o, valid_o, data_o, en_o
    );
endinterface

// File: rtl/stall_collapse_pipe.sv
// N-stage valid/ready pipeline with bubble-collapsing stalls and per-element data segments.
// Define STALL_COLLAPSE_DATA_GATE_EN to keep bubbles from loading segment data.
module stall_collapse_pipe #(
    parameter int              stages_p                  = 3,
    parameter int              widths_p [stages_p-1:0]   = '{64, 32, 16},
    parameter int              width_sum_p               = 112,
    parameter logic [stages_p-1:0] skip_p                = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    stall_collapse_pipe_if.slave  pipe
);

    function automatic int seg_off(input int idx);
        int s;
        s = 0;
        for (int k = 0; k < idx; k++) s += widths_p[k];
        return s;
    endfunction

    logic [stages_p-1:0] v_q, v_d;
    logic [stages_p-1:0] v, vin, rdy, en;
    logic                carry;

    // Valids resolve input-to-output (skipped elements pass through), readies output-to-input.
    always_comb begin
        v_d   = v_q;
        v     = '0;
        vin   = '0;
        rdy   = '0;
        en    = '0;
        carry = pipe.valid_i;
        for (int i = stages_p - 1; i >= 0; i--) begin
            vin[i] = carry;
            v[i]   = skip_p[i] ? vin[i] : v_q[i];
            carry  = v[i];
        end
        carry = pipe.ready_and_i;
        for (int i = 0; i < stages_p; i++) begin
            rdy[i] = skip_p[i] ? carry : (~v[i] | carry);
            carry  = rdy[i];
            v_d[i] = skip_p[i] ? 1'b0 : (rdy[i] ? vin[i] : v_q[i]);
`ifdef STALL_COLLAPSE_DATA_GATE_EN
            en[i]  = rdy[i] & vin[i];
`else
            en[i]  = rdy[i];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) v_q <= '0;
        else            v_q <= v_d;
    end

    assign pipe.ready_and_o = rdy[stages_p-1];
    assign pipe.valid_o     = v[0];
    assign pipe.en_o        = en;

    for (genvar i = 0; i < stages_p; i++) begin : g_seg
        localparam int off_lp = seg_off(i);
        localparam int w_lp   = widths_p[i];
        if (skip_p[i]) begin : g_skip
            assign pipe.data_o[off_lp +: w_lp] = pipe.data_i[off_lp +: w_lp];
        end else begin : g_reg
            logic [w_lp-1:0] seg_q;
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i)  seg_q <= '0;
                else if (en[i])  seg_q <= pipe.data_i[off_lp +: w_lp];
            end
            assign pipe.data_o[off_lp +: w_lp] = seg_q;
        end
    end

endmodule

// File: tb/tb_stall_collapse_pipe.sv
// Scoreboard bench for stall_collapse_pipe: a full 3-element pipe and one with element 1 skipped.
module tb_stall_collapse_pipe;

    logic        clk;
    logic        rst_n;
    logic        vld  [2];
    logic        rdyi [2];
    logic [31:0] ain  [2];
    logic [31:0] bin  [2];

    int vectors;
    int miscompares;
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    stall_collapse_pipe_if #(.stages_p(3), .width_sum_p(112)) ifa ();
    stall_collapse_pipe_if #(.stages_p(3), .width_sum_p(112)) ifb ();

    stall_collapse_pipe #(.stages_p(3), .widths_p('{64, 32, 16}), .width_sum_p(112), .skip_p(3'b000))
        dut_a (.clk_i(clk), .reset_n_i(rst_n), .pipe(ifa));
    stall_collapse_pipe #(.stages_p(3), .widths_p('{64, 32, 16}), .width_sum_p(112), .skip_p(3'b010))
        dut_b (.clk_i(clk), .reset_n_i(rst_n), .pipe(ifb));

    // User datapath: seg2 = {a,b}, seg1 = a*b, seg0 = c[31:16] + c[15:0].
    logic [31:0] prod_a, prod_b;
    logic [15:0] sum_a, sum_b;
    assign prod_a = ifa.data_o[111:80] * ifa.data_o[79:48];
    assign sum_a  = ifa.data_o[47:32] + ifa.data_o[31:16];
    assign prod_b = ifb.data_o[111:80] * ifb.data_o[79:48];
    assign sum_b  = ifb.data_o[47:32] + ifb.data_o[31:16];

    assign ifa.data_i      = {ain[0], bin[0], prod_a, sum_a};
    assign ifb.data_i      = {ain[1], bin[1], prod_b, sum_b};
    assign ifa.valid_i     = vld[0];
    assign ifb.valid_i     = vld[1];
    assign ifa.ready_and_i = rdyi[0];
    assign ifb.ready_and_i = rdyi[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] exp_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = a * b;
        return p[31:16] + p[15:0];
    endfunction

    function automatic logic rdy_o(input int sel);
        return (sel == 0) ? ifa.ready_and_o : ifb.ready_and_o;
    endfunction

    function automatic logic vo(input int sel);
        return (sel == 0) ? ifa.valid_o : ifb.valid_o;
    endfunction

    always @(negedge clk) begin
        if (rst_n && ifa.valid_o && ifa.ready_and_i) begin
            if (exp_q0.size() == 0) chk("a_extra_output", 1, 0);
            else                    chk("a_data", ifa.data_o[15:0], exp_q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifb.valid_o && ifb.ready_and_i) begin
            if (exp_q1.size() == 0) chk("b_extra_output", 1, 0);
            else                    chk("b_data", ifb.data_o[15:0], exp_q1.pop_front());
        end
    end

    task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b, output int stalls);
        int n;
        n = 0;
        ain[sel] = a;
        bin[sel] = b;
        vld[sel] = 1'b1;
        @(negedge clk);
        while (!rdy_o(sel) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!rdy_o(sel)) chk("send_timeout", 0, 1);
        else if (sel == 0) exp_q0.push_back(exp_f(a, b));
        else               exp_q1.push_back(exp_f(a, b));
        stalls = n;
        @(posedge clk);
        #1;
        vld[sel] = 1'b0;
        ain[sel] = 32'hDEADBEEF;
        bin[sel] = 32'hDEADBEEF;
    endtask

    task automatic latency(input int sel, input int exp_lat, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vo(sel) && n < 20);
        chk(name, n, exp_lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdyi[0] = 1'b1;
        rdyi[1] = 1'b1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_left", exp_q0.size() + exp_q1.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld[k]  = 1'b0;
            rdyi[k] = 1'b1;
            ain[k]  = '0;
            bin[k]  = '0;
        end
        #1;
        chk("rst_a_valid", ifa.valid_o, 0);
        chk("rst_a_data", ifa.data_o, 0);
        chk("rst_a_ready", ifa.ready_and_o, 1);
        chk("rst_b_valid", ifb.valid_o, 0);
        chk("rst_b_data", ifb.data_o, 0);
        chk("rst_b_ready", ifb.ready_and_o, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single item through the full pipe.
        send(0, 32'h0001_0000, 32'd3, s);
        latency(0, 3, "lat_full");
        drain();

        // Full-rate stream.
        for (int i = 1; i <= 8; i++) begin
            send(0, i, 32'd2, s);
            chk("stream_no_stall", s, 0);
        end
        drain();

        // Fill, stall, release.
        rdyi[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            send(0, 10 + i, 32'd5, s);
            chk("fill_no_stall", s, 0);
        end
        @(negedge clk);
        chk("full_ready_low", ifa.ready_and_o, 0);
        chk("full_valid_high", ifa.valid_o, 1);
        fork
            send(0, 32'd20, 32'd5, s);
            begin
                repeat (3) @(posedge clk);
                #1;
                rdyi[0] = 1'b1;
            end
        join
        chk("stalled_send_waited", s > 0, 1);
        drain();

        // Bubble collapse under backpressure.
        rdyi[0] = 1'b0;
        send(0, 32'd7, 32'd3, s);
        @(posedge clk);
        #1;
        send(0, 32'd9, 32'd4, s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bub_valid", ifa.valid_o, 1);
        chk("bub_ready_slot", ifa.ready_and_o, 1);
`ifdef STALL_COLLAPSE_DATA_GATE_EN
        chk("bub_en", ifa.en_o, 3'b000);
`else
        chk("bub_en", ifa.en_o, 3'b100);
`endif
        @(posedge clk);
        #1;
        rdyi[0] = 1'b1;
        @(negedge clk);
        chk("bub_adj_first", ifa.valid_o, 1);
        @(negedge clk);
        chk("bub_adj_second", ifa.valid_o, 1);
        @(negedge clk);
        chk("bub_empty_after", ifa.valid_o, 0);
        drain();

        // Skipped middle element: two-cycle latency, same results.
        send(1, 32'h0001_0000, 32'd3, s);
        latency(1, 2, "lat_skip");
        drain();
        for (int i = 1; i <= 4; i++) begin
            send(1, 32'h0000_1001 * i, 32'd300 + i, s);
            chk("skip_no_stall", s, 0);
        end
        drain();

        // Async reset with items in flight.
        rdyi[0] = 1'b0;
        rdyi[1] = 1'b0;
        send(0, 32'd5, 32'd6, s);
        send(0, 32'd7, 32'd8, s);
        send(1, 32'd2, 32'd3, s);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", ifa.valid_o, 0);
        chk("mid_rst_a_data", ifa.data_o, 0);
        chk("mid_rst_a_ready", ifa.ready_and_o, 1);
        chk("mid_rst_b_valid", ifb.valid_o, 0);
        chk("mid_rst_b_data", ifb.data_o, 0);
        exp_q0.delete();
        exp_q1.delete();
        rdyi[0] = 1'b1;
        rdyi[1] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", ifa.valid_o, 0);
        @(posedge clk);
        #1;
        send(0, 32'd100, 32'd7, s);
        latency(0, 3, "lat_post_rst");
        drain();

        // Bubble right behind an item.
        send(0, 32'h0000_1234, 32'h0000_5678, s);
        @(negedge clk);
`ifdef STALL_COLLAPSE_DATA_GATE_EN
        chk("bubble_en", ifa.en_o, 3'b010);
`else
        chk("bubble_en", ifa.en_o, 3'b111);
`endif
        @(posedge clk);
        #1;
`ifdef STALL_COLLAPSE_DATA_GATE_EN
        chk("bubble_seg2", ifa.data_o[111:48], 64'h0000_1234_0000_5678);
`else
        chk("bubble_seg2", ifa.data_o[111:48], 64'hDEAD_BEEF_DEAD_BEEF);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stall_collapse_pipe.md
Name: stall_collapse_pipe

Overview:
Generic N-stage valid/ready pipeline with bubble-collapsing stall control and per-stage segmented data registers.
- User datapath logic sits outside the block: it reads stage outputs from data_o and drives next-stage inputs on data_i.
- Handshakes are valid/ready-and at both ends.
- Sits between any producer and consumer that need a multi-cycle registered datapath (e.g. multiply then add).

Parameters:
- stages_p, 3: number of pipeline stages (elements).
- widths_p, {64,32,16}: int array [stages_p-1:0]; widths_p[i] is the data width of element i.
- width_sum_p, 112: sum of widths_p; must equal the total.
- skip_p, 0: stages_p-bit mask; bit i=1 removes the registers of element i (combinational pass-through).

Ports:
- clk_i, in, 1: clock, rising edge.
- reset_n_i, in, 1: asynchronous active-low reset.
- valid_i, in, 1: upstream valid.
- ready_and_o, out, 1: block can accept this cycle.
- valid_o, out, 1: output element holds valid data.
- ready_and_i, in, 1: downstream accepts.
- data_i, in, width_sum_p: next-value inputs for all segments.
- data_o, out, width_sum_p: registered segment values.
- en_o, out, stages_p: per-element load enables (debug/observe).

Behaviour:
- Element indexing: element stages_p-1 is nearest the input; element 0 drives valid_o.
- Segment packing: element i occupies bits starting at offset sum(widths_p[0..i-1]), so element 0 is in the LSBs.
- Valid input per element: vin[stages_p-1] = valid_i; vin[i] = v[i+1].
- Ready chain, combinational, no registered ready: rdy[0] = ~v[0] | ready_and_i; rdy[i] = ~v[i] | rdy[i-1].
- ready_and_o = rdy[stages_p-1]. valid_o = v[0].
- Registered element i, at the clock edge when rdy[i]=1:
  - v[i] <= vin[i];
  - segment i <= data_i segment i.
  - Otherwise v[i] and the segment hold.
- en_o[i] = rdy[i] by default (see Optional Feature).
- Bubble collapse: an empty element loads even while downstream is stalled, so gaps close under backpressure.
- Stalled full pipe: all rdy=0 and all elements hold.
- Skipped element i (skip_p[i]=1):
  - v[i] = vin[i] combinationally;
  - segment i of data_o = segment i of data_i;
  - rdy[i] = rdy[i-1] (ready_and_i for i=0);
  - en_o[i] = rdy[i].
- Latency: stages_p minus popcount(skip_p) cycles from input handshake to valid_o. Throughput 1 item/cycle when ready_and_i=1.
- Reset (reset_n_i=0, async): all v cleared, all data segments cleared to 0. Hence valid_o=0, data_o=0, ready_and_o=1.
- Reset asserted mid-operation drops all in-flight items; the first cycle after deassert behaves as empty.
- Simultaneous events: an output handshake (valid_o & ready_and_i) and an input acceptance in the same cycle are both honoured when the pipe is full (full-rate streaming).
- Data in an element with v=0 is don't-care to consumers.

Optional Feature:
- Macro STALL_COLLAPSE_DATA_GATE_EN.
- Defined: segment enable = rdy[i] & vin[i], so bubbles do not load data (power saving). v[i] still loads on rdy[i]. en_o reflects the gated enable.
- Undefined: segment enable = rdy[i].
- Handshake behaviour and valid-data results are identical either way.

Test Plan:
- Common setup: stages_p=3, widths {64,32,16}. Bench wiring:
  - seg2 = {a,b} from inputs;
  - seg1 = a*b (lower 32 bits);
  - seg0 = c[31:16]+c[15:0].
- Single item, a=0x10000, b=3, ready_and_i=1 -> valid_o high exactly 3 cycles after accept, data_o[15:0]=0x0003.
- Stream a=1..8, b=2, ready_and_i=1 -> one result per cycle; outputs 2,4,...,16 in order; ready_and_o stays 1.
- Fill then stall (ready_and_i=0) -> ready_and_o drops after 3 accepts. Release -> results in order, none lost or duplicated.
- Bubble collapse: send item at cycle 0, idle 1 cycle, send item at cycle 2, with ready_and_i=0 until the pipe has 2 items -> both items adjacent at the output, ready_and_o=1 while an empty slot remains.
- skip_p=3'b010 -> latency 2 cycles, same results. Async reset pulse mid-stream -> valid_o=0 and data_o=0 immediately.
- Bubble data check: with the macro defined, a bubble following an item leaves the upstream segment value unchanged, and en_o shows the gated enable.
